// File: rtl/snake_display_pkg.sv
// Shared glyph geometry, FSM state encoding and glyph bit lookup for the score display.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package snake_display_pkg;

   localparam int GLYPH_W    = 6;
   localparam int GLYPH_H    = 5;
   localparam int NUM_DIGITS = 3;
   localparam int GLYPH_BITS = 30;

   // Bit pattern of the "0" glyph, used to detect leading zeros.
   localparam logic [GLYPH_BITS-1:0] GLYPH_ZERO = 30'h0C5A64CC;

   typedef enum logic [1:0] {
      IDLE,
      PLOT,
      DONE
   } state_t;

   // Digit d occupies a 30-bit slice; row r is six bits inside it; column c is bit c of the row.
   function automatic logic glyph_bit(
      input logic [GLYPH_BITS*NUM_DIGITS-1:0] glyphs,
      input logic [1:0]                       d,
      input logic [2:0]                       r,
      input logic [2:0]                       c
   );
      logic [6:0] idx;
      idx = ({5'd0, d} * 7'd30) + ({4'd0, r} * 7'd6) + {4'd0, c};
      return glyphs[idx];
   endfunction

endpackage

// File: rtl/glyph_pixel_counter.sv
// Walks every glyph cell: column fastest, then row, then digit; flags the final cell.
// Latency: count updates one clock after clear/advance; last is combinational from the count.
// Backpressure: none; the count only moves when advance is asserted.
module glyph_pixel_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       advance,
   output logic [1:0] d,
   output logic [2:0] r,
   output logic [2:0] c,
   output logic       last
);

   assign last = (d == 2'd2) && (r == 3'd4) && (c == 3'd5);

   // Nested column/row/digit counters; clear has priority over advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d <= '0;
         r <= '0;
         c <= '0;
      end else if (clear) begin
         d <= '0;
         r <= '0;
         c <= '0;
      end else if (advance) begin
         if (c == 3'd5) begin
            c <= '0;
            if (r == 3'd4) begin
               r <= '0;
               d <= (d == 2'd2) ? 2'd0 : d + 2'd1;
            end else begin
               r <= r + 3'd1;
            end
         end else begin
            c <= c + 3'd1;
         end
      end
   end

endmodule

// File: rtl/score_glyph_plotter.sv
// Draws the latched three-digit score glyphs into the frame buffer, one pixel per clock, erasing with BG.
// Latency: start at edge T -> plots T+1..T+90, done pulse at T+91; optional SCORE_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Backpressure: none; start is ignored while busy, the frame buffer must accept a write every cycle.
module score_glyph_plotter
   import snake_display_pkg::*;
#(
   parameter logic [7:0] X_ORIGIN    = 8'd4,
   parameter logic [6:0] Y_ORIGIN    = 7'd2,
   parameter logic [3:0] DIGIT_PITCH = 4'd6,
   parameter logic [2:0] FG_COLOUR   = 3'b111,
   parameter logic [2:0] BG_COLOUR   = 3'b000
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic [GLYPH_BITS*NUM_DIGITS-1:0]   glyphs,
   output logic [7:0]                         x,
   output logic [6:0]                         y,
   output logic [2:0]                         colour,
   output logic                               plot,
   output logic                               busy,
   output logic                               done
);

   state_t                             state_q;
   state_t                             state_d;
   logic [GLYPH_BITS*NUM_DIGITS-1:0]   glyph_q;
   logic                               latch;
   logic                               cnt_clear;
   logic                               cnt_adv;
   logic                               plot_d;
   logic                               done_d;
   logic                               busy_d;
   logic [1:0]                         cnt_d;
   logic [2:0]                         cnt_r;
   logic [2:0]                         cnt_c;
   logic                               cnt_last;
   logic                               pix_on;
   logic [7:0]                         pix_x;
   logic [6:0]                         pix_y;

   glyph_pixel_counter u_counter (
      .clk     (clk),
      .reset   (reset),
      .clear   (cnt_clear),
      .advance (cnt_adv),
      .d       (cnt_d),
      .r       (cnt_r),
      .c       (cnt_c),
      .last    (cnt_last)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state plus the next values of the registered control outputs.
   always_comb begin
      state_d   = state_q;
      latch     = 1'b0;
      cnt_clear = 1'b0;
      cnt_adv   = 1'b0;
      plot_d    = 1'b0;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               latch     = 1'b1;
               cnt_clear = 1'b1;
               busy_d    = 1'b1;
               state_d   = PLOT;
            end
         end
         PLOT: begin
            plot_d  = 1'b1;
            cnt_adv = 1'b1;
            busy_d  = 1'b1;
            if (cnt_last) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Snapshot the glyph bus so later changes cannot disturb a redraw in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      glyph_q <= '0;
      else if (latch) glyph_q <= glyphs;
   end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] blank_q;

   // Leading-zero flags: tens only blanks behind a blank hundreds; ones always drawn.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blank_q <= '0;
      end else if (latch) begin
         blank_q[0] <= (glyphs[29:0] == GLYPH_ZERO);
         blank_q[1] <= (glyphs[29:0] == GLYPH_ZERO) && (glyphs[59:30] == GLYPH_ZERO);
         blank_q[2] <= 1'b0;
      end
   end

   assign pix_on = glyph_bit(glyph_q, cnt_d, cnt_r, cnt_c) && !blank_q[cnt_d];
`else
   assign pix_on = glyph_bit(glyph_q, cnt_d, cnt_r, cnt_c);
`endif

   assign pix_x = X_ORIGIN + ({6'd0, cnt_d} * {4'd0, DIGIT_PITCH}) + {5'd0, cnt_c};
   assign pix_y = Y_ORIGIN + {4'd0, cnt_r};

   // Registered pixel and handshake outputs; coordinates hold whenever no write is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         plot <= plot_d;
         busy <= busy_d;
         done <= done_d;
         if (plot_d) begin
            x      <= pix_x;
            y      <= pix_y;
            colour <= pix_on ? FG_COLOUR : BG_COLOUR;
         end
      end
   end

   // Every write must land inside the 160x120 frame buffer.
   extent_chk: assert property (@(posedge clk) disable iff (reset)
      plot |-> ((x < 8'd160) && (y < 7'd120)));

endmodule

// File: tb/tb_score_glyph_plotter.sv
module tb_score_glyph_plotter;

   localparam logic [29:0] G_ZERO  = 30'h0C5A64CC;
   localparam logic [29:0] G_ONE   = {6'b011100, 6'b001000, 6'b001000, 6'b001100, 6'b001000};
   localparam logic [29:0] G_TWO   = {6'b011110, 6'b000100, 6'b001000, 6'b010010, 6'b001100};
   localparam logic [29:0] G_SEVEN = {6'b000100, 6'b000100, 6'b001000, 6'b010000, 6'b011110};
   localparam logic [29:0] G_NINE  = {6'b001100, 6'b010000, 6'b011100, 6'b010010, 6'b001100};

   logic        clk;
   logic        reset;
   logic        start;
   logic [89:0] glyphs;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        busy;
   logic        done;

   int n_vec;
   int n_err;

   logic       cap_plot [1:100];
   logic [7:0] cap_x    [1:100];
   logic [6:0] cap_y    [1:100];
   logic [2:0] cap_col  [1:100];
   logic       cap_busy [1:100];
   logic       cap_done [1:100];

   score_glyph_plotter dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .glyphs (glyphs),
      .x      (x),
      .y      (y),
      .colour (colour),
      .plot   (plot),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference colour of cell (d,r,c) of bus g, with leading-zero blanking when built in.
   function automatic logic [2:0] model_colour(input logic [89:0] g, input int d, input int r, input int c);
      bit blank_h;
      bit blank_t;
      blank_h = 1'b0;
      blank_t = 1'b0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      blank_h = (g[29:0] == G_ZERO);
      blank_t = blank_h && (g[59:30] == G_ZERO);
`endif
      if ((d == 0 && blank_h) || (d == 1 && blank_t)) return 3'b000;
      return g[d*30 + r*6 + c] ? 3'b111 : 3'b000;
   endfunction

   // Called at a negedge: start sampled at the next edge T, records outputs after edges T+1..T+ncyc.
   task automatic launch_capture(input logic [89:0] g, input logic [89:0] g_alt, input int change_k,
                                 input int s1, input int s2, input int ncyc);
      glyphs = g;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         start = (k == s1 || k == s2) ? 1'b1 : 1'b0;
         if (change_k != 0 && k == change_k) glyphs = g_alt;
         @(posedge clk);
         @(negedge clk);
         cap_plot[k] = plot;
         cap_x[k]    = x;
         cap_y[k]    = y;
         cap_col[k]  = colour;
         cap_busy[k] = busy;
         cap_done[k] = done;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      start  = 1'b0;
      glyphs = '0;
      repeat (2) @(negedge clk);
      n_vec++; if (x !== 8'd0)      begin n_err++; $display("FAIL reset_x got %0d want 0", x); end
      n_vec++; if (y !== 7'd0)      begin n_err++; $display("FAIL reset_y got %0d want 0", y); end
      n_vec++; if (colour !== 3'd0) begin n_err++; $display("FAIL reset_colour got %0d want 0", colour); end
      n_vec++; if (plot !== 1'b0)   begin n_err++; $display("FAIL reset_plot got %b want 0", plot); end
      n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zeros();
      logic [89:0] g;
      g = {G_ZERO, G_ZERO, G_ZERO};
      launch_capture(g, g, 0, 0, 0, 93);
      n_vec++;
      if (cap_plot[1] !== 1'b1 || cap_x[1] !== 8'd4 || cap_y[1] !== 7'd2 || cap_col[1] !== 3'b000) begin
         n_err++;
         $display("FAIL zeros_first plot=%b x=%0d y=%0d col=%0d want plot=1 x=4 y=2 col=0",
                  cap_plot[1], cap_x[1], cap_y[1], cap_col[1]);
      end
      for (int k = 1; k <= 90; k++) begin
         int p;
         int d;
         int r;
         int c;
         p = k - 1; d = p / 30; r = (p % 30) / 6; c = p % 6;
         n_vec++;
         if (cap_plot[k] !== 1'b1 || cap_x[k] !== 8'(4 + 6*d + c) || cap_y[k] !== 7'(2 + r) ||
             cap_col[k] !== model_colour(g, d, r, c)) begin
            n_err++;
            $display("FAIL zeros_pixel k=%0d got plot=%b x=%0d y=%0d col=%0d want plot=1 x=%0d y=%0d col=%0d",
                     k, cap_plot[k], cap_x[k], cap_y[k], cap_col[k], 4 + 6*d + c, 2 + r, model_colour(g, d, r, c));
         end
      end
      for (int k = 1; k <= 93; k++) begin
         n_vec++;
         if (cap_done[k] !== (k == 91)) begin
            n_err++; $display("FAIL zeros_done k=%0d got %b want %b", k, cap_done[k], (k == 91));
         end
      end
      n_vec++; if (cap_plot[91] !== 1'b0) begin n_err++; $display("FAIL zeros_plot_end got %b want 0", cap_plot[91]); end
      n_vec++; if (cap_busy[90] !== 1'b1) begin n_err++; $display("FAIL zeros_busy_90 got %b want 1", cap_busy[90]); end
      n_vec++; if (cap_busy[91] !== 1'b0) begin n_err++; $display("FAIL zeros_busy_91 got %b want 0", cap_busy[91]); end
      n_vec++;
      if (cap_x[93] !== 8'd21 || cap_y[93] !== 7'd6) begin
         n_err++; $display("FAIL zeros_hold got x=%0d y=%0d want x=21 y=6", cap_x[93], cap_y[93]);
      end
   endtask

   task automatic test_seven();
      logic [89:0] g;
      logic [2:0]  exp_row [6];
      g = {G_SEVEN, G_ZERO, G_ZERO};
      exp_row = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
      launch_capture(g, g, 0, 0, 0, 92);
      for (int c = 0; c < 6; c++) begin
         n_vec++;
         if (cap_plot[61+c] !== 1'b1 || cap_x[61+c] !== 8'(16 + c) || cap_y[61+c] !== 7'd2 ||
             cap_col[61+c] !== exp_row[c]) begin
            n_err++;
            $display("FAIL seven_row0 c=%0d got plot=%b x=%0d y=%0d col=%0d want plot=1 x=%0d y=2 col=%0d",
                     c, cap_plot[61+c], cap_x[61+c], cap_y[61+c], cap_col[61+c], 16 + c, exp_row[c]);
         end
      end
      for (int k = 1; k <= 90; k++) begin
         int p;
         p = k - 1;
         n_vec++;
         if (cap_col[k] !== model_colour(g, p / 30, (p % 30) / 6, p % 6)) begin
            n_err++;
            $display("FAIL seven_pixel k=%0d got col=%0d want col=%0d", k, cap_col[k],
                     model_colour(g, p / 30, (p % 30) / 6, p % 6));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [89:0] g;
      int nplot;
      int ndone;
      g = {G_TWO, G_ONE, G_NINE};
      launch_capture(g, g, 0, 10, 50, 91);
      nplot = 0;
      ndone = 0;
      for (int k = 1; k <= 91; k++) begin
         if (cap_plot[k] === 1'b1) nplot++;
         if (cap_done[k] === 1'b1) ndone++;
      end
      n_vec++; if (nplot != 90) begin n_err++; $display("FAIL b2b_plot_count got %0d want 90", nplot); end
      n_vec++; if (ndone != 1)  begin n_err++; $display("FAIL b2b_done_count got %0d want 1", ndone); end
      n_vec++; if (cap_done[91] !== 1'b1) begin n_err++; $display("FAIL b2b_done_91 got %b want 1", cap_done[91]); end
      n_vec++; if (cap_busy[50] !== 1'b1) begin n_err++; $display("FAIL b2b_busy_50 got %b want 1", cap_busy[50]); end
      // Start sampled at T+92, directly after done.
      launch_capture(g, g, 0, 0, 0, 92);
      n_vec++;
      if (cap_plot[1] !== 1'b1 || cap_x[1] !== 8'd4 || cap_y[1] !== 7'd2 || cap_busy[1] !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_restart got plot=%b x=%0d y=%0d busy=%b want plot=1 x=4 y=2 busy=1",
                  cap_plot[1], cap_x[1], cap_y[1], cap_busy[1]);
      end
      n_vec++; if (cap_done[91] !== 1'b1) begin n_err++; $display("FAIL b2b_restart_done got %b want 1", cap_done[91]); end
   endtask

   task automatic test_abort();
      logic [89:0] g;
      int ndone;
      g = {G_SEVEN, G_TWO, G_ONE};
      launch_capture(g, g, 0, 0, 0, 40);
      n_vec++; if (cap_plot[40] !== 1'b1) begin n_err++; $display("FAIL abort_pre_plot got %b want 1", cap_plot[40]); end
      reset = 1'b1;
      #1;
      n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL abort_plot got %b want 0", plot); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
      n_vec++; if (x !== 8'd0 || y !== 7'd0) begin n_err++; $display("FAIL abort_xy got x=%0d y=%0d want 0 0", x, y); end
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done === 1'b1 || plot === 1'b1) ndone++;
      end
      n_vec++; if (ndone != 0) begin n_err++; $display("FAIL abort_no_done got %0d active cycles want 0", ndone); end
      launch_capture(g, g, 0, 0, 0, 92);
      n_vec++;
      if (cap_plot[1] !== 1'b1 || cap_x[1] !== 8'd4 || cap_y[1] !== 7'd2) begin
         n_err++;
         $display("FAIL abort_restart got plot=%b x=%0d y=%0d want plot=1 x=4 y=2", cap_plot[1], cap_x[1], cap_y[1]);
      end
      n_vec++; if (cap_done[91] !== 1'b1) begin n_err++; $display("FAIL abort_restart_done got %b want 1", cap_done[91]); end
   endtask

   task automatic test_glyph_change();
      logic [89:0] g;
      logic [89:0] g_alt;
      g     = {G_TWO, G_ONE, G_ZERO};
      g_alt = {G_NINE, G_NINE, G_NINE};
      launch_capture(g, g_alt, 20, 0, 0, 92);
      for (int k = 1; k <= 90; k++) begin
         int p;
         p = k - 1;
         n_vec++;
         if (cap_plot[k] !== 1'b1 || cap_col[k] !== model_colour(g, p / 30, (p % 30) / 6, p % 6)) begin
            n_err++;
            $display("FAIL change_pixel k=%0d got plot=%b col=%0d want plot=1 col=%0d", k, cap_plot[k], cap_col[k],
                     model_colour(g, p / 30, (p % 30) / 6, p % 6));
         end
      end
   endtask

   task automatic test_blank();
      int n_lead;
      int n_ones;
      int n_h;
      int n_t;
      int exp_lead;
      launch_capture({G_SEVEN, G_ZERO, G_ZERO}, {G_SEVEN, G_ZERO, G_ZERO}, 0, 0, 0, 92);
      n_lead = 0;
      n_ones = 0;
      for (int k = 1; k <= 60; k++) if (cap_col[k] === 3'b111) n_lead++;
      for (int k = 61; k <= 90; k++) if (cap_col[k] === 3'b111) n_ones++;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      exp_lead = 0;
`else
      exp_lead = 26;
`endif
      n_vec++; if (n_lead != exp_lead) begin n_err++; $display("FAIL blank_007_lead got %0d fg cells want %0d", n_lead, exp_lead); end
      n_vec++; if (n_ones != 8) begin n_err++; $display("FAIL blank_007_ones got %0d fg cells want 8", n_ones); end
      launch_capture({G_ZERO, G_ZERO, G_ONE}, {G_ZERO, G_ZERO, G_ONE}, 0, 0, 0, 92);
      n_h = 0;
      n_t = 0;
      for (int k = 1; k <= 30; k++) if (cap_col[k] === 3'b111) n_h++;
      for (int k = 31; k <= 60; k++) if (cap_col[k] === 3'b111) n_t++;
      n_vec++; if (n_h != 8)  begin n_err++; $display("FAIL blank_100_hundreds got %0d fg cells want 8", n_h); end
      n_vec++; if (n_t != 13) begin n_err++; $display("FAIL blank_100_tens got %0d fg cells want 13", n_t); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_zeros();
      test_seven();
      test_back_to_back();
      test_abort();
      test_glyph_change();
      test_blank();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
